// File: rtl/flag_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flag_pkg : shared colour/palette types and width helpers for the flag    |
// |            stripe renderer.                                               |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package flag_pkg;

  localparam int CW = 6;

  typedef logic [CW-1:0] color_t;

  localparam color_t COLOR_BLACK = '0;

  typedef struct packed {
    color_t a;
    color_t b;
    logic   dither;
  } pal_entry_t;

  function automatic int stripe_idx_w(input int max_stripes);
    return (max_stripes > 2) ? $clog2(max_stripes) : 1;
  endfunction

  function automatic int stripe_cnt_w(input int max_stripes);
    return $clog2(max_stripes + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stripe_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stripe_tracker : divider-free stripe index from a line-rate accumulator. |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module stripe_tracker
  import flag_pkg::*;
#(
  parameter int V_ACTIVE    = 480,
  parameter int MAX_STRIPES = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     frame_start,
  input  logic                                     line_start,
  input  logic [stripe_cnt_w(MAX_STRIPES)-1:0]     cfg_stripes,
  output logic [stripe_idx_w(MAX_STRIPES)-1:0]     stripe
);

  localparam int SW = stripe_idx_w(MAX_STRIPES);
  localparam int NW = stripe_cnt_w(MAX_STRIPES);
  localparam int AW = $clog2(V_ACTIVE + MAX_STRIPES);
  localparam logic [NW-1:0] N_MAX = NW'(MAX_STRIPES);
  localparam logic [AW-1:0] H     = AW'(V_ACTIVE);

  logic [NW-1:0] n_lat_q, n_lat_d, n_new;
  logic [AW-1:0] acc_q, acc_d, acc_sum;
  logic [SW-1:0] stripe_q, stripe_d;
  logic          first_line_q, first_line_d;

  always_comb begin
    n_new = cfg_stripes;
    if (cfg_stripes == '0) begin
      n_new = NW'(1);
    end else if (cfg_stripes > N_MAX) begin
      n_new = N_MAX;
    end
  end

  // acc + stripe*H tracks (y+1)*n - 1, so stripe is the exact quotient by H
  assign acc_sum = acc_q + AW'(n_lat_q);

  always_comb begin
    n_lat_d      = n_lat_q;
    acc_d        = acc_q;
    stripe_d     = stripe_q;
    first_line_d = first_line_q;
    if (frame_start) begin
      n_lat_d      = n_new;
      acc_d        = AW'(n_new - NW'(1));
      stripe_d     = '0;
      first_line_d = 1'b1;
    end else if (line_start) begin
      if (first_line_q) begin
        first_line_d = 1'b0;
      end else if (acc_sum >= H) begin
        acc_d = acc_sum - H;
        if (NW'(stripe_q) < (n_lat_q - NW'(1))) begin
          stripe_d = stripe_q + SW'(1);
        end
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat_q      <= NW'(1);
      acc_q        <= '0;
      stripe_q     <= '0;
      first_line_q <= 1'b1;
    end else begin
      n_lat_q      <= n_lat_d;
      acc_q        <= acc_d;
      stripe_q     <= stripe_d;
      first_line_q <= first_line_d;
    end
  end

  assign stripe = stripe_q;

endmodule
`default_nettype wire

// File: rtl/flag_stripe_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flag_stripe_engine : run-time configurable horizontal-stripe flag with a |
// |   double-buffered solid/checkerboard palette committed at frame start.  |
// |   Option FLAG_FRAME_DITHER_EN adds a per-frame checkerboard phase flip.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module flag_stripe_engine #(
  parameter int V_ACTIVE    = 480,
  parameter int MAX_STRIPES = 8,
  parameter int CW          = flag_pkg::CW
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           frame_start,
  input  logic                                           line_start,
  input  logic                                           video_active,
  input  logic [9:0]                                     pix_x,
  input  logic [9:0]                                     pix_y,
  input  logic [flag_pkg::stripe_cnt_w(MAX_STRIPES)-1:0] cfg_stripes,
  input  logic                                           pal_valid,
  output logic                                           pal_ready,
  input  logic [flag_pkg::stripe_idx_w(MAX_STRIPES)-1:0] pal_idx,
  input  logic [CW-1:0]                                  pal_color_a,
  input  logic [CW-1:0]                                  pal_color_b,
  input  logic                                           pal_dither,
  output logic [CW-1:0]                                  color
);

  localparam int SW = flag_pkg::stripe_idx_w(MAX_STRIPES);

  flag_pkg::pal_entry_t shadow_q [MAX_STRIPES];
  flag_pkg::pal_entry_t shadow_d [MAX_STRIPES];
  flag_pkg::pal_entry_t active_q [MAX_STRIPES];
  flag_pkg::pal_entry_t active_d [MAX_STRIPES];
  flag_pkg::pal_entry_t cur_entry;

  logic          dirty_q, dirty_d;
  logic [CW-1:0] color_q, color_d;
  logic [SW-1:0] stripe;
  logic          phase, sel, pal_fire;
  logic          unused_pix;

  stripe_tracker #(
    .V_ACTIVE    (V_ACTIVE),
    .MAX_STRIPES (MAX_STRIPES)
  ) u_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .line_start  (line_start),
    .cfg_stripes (cfg_stripes),
    .stripe      (stripe)
  );

  // Writes are refused on the commit cycle so a commit never races a write
  assign pal_ready = rst_n & ~frame_start;
  assign pal_fire  = pal_valid & pal_ready;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    dirty_d  = dirty_q;
    if (frame_start && dirty_q) begin
      active_d = shadow_q;
      dirty_d  = 1'b0;
    end
    if (pal_fire && (int'(pal_idx) < MAX_STRIPES)) begin
      shadow_d[pal_idx] = '{a: pal_color_a, b: pal_color_b, dither: pal_dither};
      dirty_d           = 1'b1;
    end
  end

`ifdef FLAG_FRAME_DITHER_EN
  logic phase_q, phase_d;

  assign phase_d = frame_start ? ~phase_q : phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;
`else
  assign phase = 1'b0;
`endif

  assign cur_entry  = active_q[stripe];
  assign sel        = pix_x[0] ^ pix_y[0] ^ phase;
  assign unused_pix = ^{pix_x[9:1], pix_y[9:1]};

  always_comb begin
    color_d = flag_pkg::COLOR_BLACK;
    if (video_active) begin
      color_d = (cur_entry.dither && sel) ? cur_entry.b : cur_entry.a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_STRIPES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      dirty_q <= 1'b0;
      color_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      dirty_q  <= dirty_d;
      color_q  <= color_d;
    end
  end

  assign color = color_q;

endmodule
`default_nettype wire

// File: doc/flag_stripe_engine.md
Name: flag_stripe_engine

Overview:
Parametrised horizontal-stripe flag renderer for the VGA pride designs. It generalises the fixed-stripe, comparator-based flag modules.
- Stripe count is selectable at run time, up to MAX_STRIPES.
- Per-stripe solid or 50% checkerboard colour pairs are loaded through a valid/ready palette port into a shadow bank, which is committed at frame start (tear-free).
- Stripe boundaries come from a line-rate accumulator, not dividers.
- It sits between the VGA timing generator and the RGB output register.

Parameters:
V_ACTIVE, 480, visible lines per frame (H in the formulas below)
MAX_STRIPES, 8, palette depth and maximum stripe count (≥2)
CW, 6, colour width (RRGGBB, 2 bits per channel)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse before the first visible line of each frame
line_start  in  1  one-cycle pulse at the start of each visible line
video_active  in  1  high during visible pixels
pix_x  in  10  current column
pix_y  in  10  current row
cfg_stripes  in  clog2(MAX_STRIPES+1)  stripe count n; sampled at frame_start
pal_valid  in  1  palette write request
pal_ready  out  1  palette write accept
pal_idx  in  clog2(MAX_STRIPES)  stripe index to write
pal_color_a  in  CW  primary colour
pal_color_b  in  CW  secondary dither colour
pal_dither  in  1  1 = checkerboard of a/b; 0 = solid a
color  out  CW  registered pixel colour

Behaviour:
- Reset state:
  - color=0, pal_ready=0 during reset.
  - Shadow and active palettes all zero, dither=0.
  - n_lat=1, acc=0, stripe=0, first_line=1, phase=0, dirty=0.
- n_lat is captured at frame_start.
  - cfg_stripes=0 is treated as 1.
  - Values > MAX_STRIPES saturate to MAX_STRIPES.
- Stripe tracking (exact; no divider):
  - Required result: stripe(y) = min(n-1, floor(((y+1)·n − 1)/H)).
  - At frame_start: acc ← n_new−1, stripe ← 0, first_line ← 1. Here n_new is the clamped value being captured that cycle.
  - First line_start after frame_start: only clears first_line.
  - Each later line_start: acc ← acc+n. If the sum ≥ H, acc ← sum−H and stripe ← stripe+1.
  - stripe saturates at n−1.
  - acc width is clog2(H+MAX_STRIPES).
- Pixel path:
  - sel = pix_x[0] ^ pix_y[0] ^ phase.
  - Colour is active_b[stripe] if dither[stripe] && sel, else active_a[stripe].
  - color is registered with latency 1 from pix_x/pix_y/video_active.
  - When video_active=0, color is 0 on the next cycle.
- Palette handshake:
  - pal_ready = !frame_start (high otherwise, once out of reset).
  - Transfer occurs when pal_valid && pal_ready. It writes shadow[pal_idx] ← {a, b, dither} and sets dirty.
  - pal_idx ≥ MAX_STRIPES: transfer is accepted and discarded; dirty unchanged.
  - Multiple writes to the same index: last write wins.
- Commit: at frame_start with dirty=1, active ← shadow and dirty ← 0. The active palette never changes mid-frame.
- Simultaneous frame_start and line_start: frame_start wins; line_start is ignored.
- Reset mid-frame: all state returns to reset values immediately (async). Rendering resumes correctly only after the next frame_start.

Optional Feature:
FLAG_FRAME_DITHER_EN
- Defined: phase toggles at every frame_start, giving a temporal plus spatial 50% dither.
- Undefined: phase is held at 0 and the register is absent.

Decomposition:
- Package flag_pkg holds:
  - CW and the colour type.
  - Constant COLOR_BLACK = 0.
  - Palette entry struct {a, b, dither}.
  - Width helper functions for stripe index and count.
- Sub-module stripe_tracker holds the accumulator, stripe counter, first_line flag and n_lat capture.

Test Plan:
- n=7, H=480, full frame of line_start pulses → stripe steps to 1..6 at rows 68, 137, 205, 274, 342, 411; row 479 gives stripe 6.
- Stripe 1 written {a=6'b111011, b=6'b111111, dither=1}, frame committed → at row 70: (x=0) gives 111011, (x=1) gives 111111; at row 71 the pattern is inverted.
- Palette write mid-frame → no colour change until the next frame_start; the new colour appears on row 0 of the following frame; dirty clears.
- pal_valid held high across frame_start → pal_ready=0 only on that cycle; the write completes the next cycle and commits on the following frame.
- cfg_stripes=0 gives a single stripe all frame; cfg_stripes=9 with MAX_STRIPES=8 gives 8 stripes. video_active=0 gives color 0 one cycle later.
- rst_n asserted mid-frame → color=0 and palette cleared asynchronously. With FLAG_FRAME_DITHER_EN, checkerboard phase alternates on successive frames at the same (x, y).
